md_unit: RTL and testbench



---
 rtl/md_unit_pkg.sv | 29 ++
 rtl/md_calc.sv | 45 ++++
 rtl/md_unit.sv | 121 ++++++++++++
 tb/tb_md_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// Shared encodings and defaults for the HI/LO multiply/divide unit.
// Multiop values match the decoder's encoding.
package md_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101,
    OP_MFLO  = 3'b110,
    OP_MFHI  = 3'b111
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // mult/multu/div/divu are exactly the encodings with bit 2 clear
  function automatic logic is_arith(input logic [2:0] op);
    return ~op[2];
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational 32x32 multiply / divide datapath; result is {HI, LO}.
// Zero latency; no flow control (pure function of Multiop, A, B).
module md_calc
  import md_unit_pkg::*;
(
  input  logic [2:0]  Multiop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] dvsr;
  logic [31:0] quo;
  logic [31:0] rem;

  // Signed divide works on magnitudes, then restores signs: quotient
  // truncates toward zero, remainder follows the dividend.
  always_comb begin
    is_signed   = ~Multiop[0];
    a_neg       = is_signed & A[31];
    b_neg       = is_signed & B[31];
    a_mag       = a_neg ? -A : A;
    b_mag       = b_neg ? -B : B;
    div_by_zero = (B == 32'd0) & Multiop[1] & ~Multiop[2];
    dvsr        = (B == 32'd0) ? 32'd1 : b_mag;
    quo         = a_mag / dvsr;
    rem         = a_mag % dvsr;

    result = '0;
    case (Multiop)
      OP_MULT:  result = {{32{A[31]}}, A} * {{32{B[31]}}, B};
      OP_MULTU: result = {32'd0, A} * {32'd0, B};
      OP_DIV,
      OP_DIVU:  result = {(a_neg ? -rem : rem), ((a_neg ^ b_neg) ? -quo : quo)};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// HI/LO owner: sequences mult/div over a fixed busy period, services mt*/mf*.
// Result commits MULT_CYCLES/DIV_CYCLES after start; starts while busy are dropped.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  Multiop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        d_md_use,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             busy_nxt;
  logic [31:0]      hi_nxt, lo_nxt;
  logic [31:0]      hi_tmp, hi_tmp_nxt;
  logic [31:0]      lo_tmp, lo_tmp_nxt;
  logic             skip, skip_nxt;

  logic [63:0]      calc_res;
  logic             calc_dbz;

  md_calc u_calc (
    .Multiop     (Multiop),
    .A           (A),
    .B           (B),
    .result      (calc_res),
    .div_by_zero (calc_dbz)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= MD_IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      hi_tmp <= '0;
      lo_tmp <= '0;
      skip   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy   <= busy_nxt;
      HI     <= hi_nxt;
      LO     <= lo_nxt;
      hi_tmp <= hi_tmp_nxt;
      lo_tmp <= lo_tmp_nxt;
      skip   <= skip_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    busy_nxt   = busy;
    hi_nxt     = HI;
    lo_nxt     = LO;
    hi_tmp_nxt = hi_tmp;
    lo_tmp_nxt = lo_tmp;
    skip_nxt   = skip;

    case (state)
      MD_IDLE: begin
        if (start && is_arith(Multiop)) begin
          {hi_tmp_nxt, lo_tmp_nxt} = calc_res;
          skip_nxt                 = calc_dbz;
          cnt_nxt                  = Multiop[1] ? DIV_LOAD : MULT_LOAD;
          busy_nxt                 = 1'b1;
          state_nxt                = MD_BUSY;
        end else if (Multiop == OP_MTHI) begin
          hi_nxt = A;
        end else if (Multiop == OP_MTLO) begin
          lo_nxt = A;
        end
      end
      MD_BUSY: begin
        cnt_nxt = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          // a divide by zero burns the full period but leaves HI/LO alone
          if (!skip) begin
            hi_nxt = hi_tmp;
            lo_nxt = lo_tmp;
          end
          busy_nxt  = 1'b0;
          state_nxt = MD_IDLE;
        end
      end
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_comb begin
    md_out = '0;
    case (Multiop)
      OP_MFHI: md_out = HI;
      OP_MFLO: md_out = LO;
      default: md_out = '0;
    endcase
  end

  assign md_stall = d_md_use & (start | busy);

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: per-cycle compare against a behavioural
// HI/LO model, directed literal checks, then randomized traffic.
module tb_md_unit;

  localparam longint MC = 5;
  localparam longint DC = 10;

  logic        clk      = 1'b0;
  logic        reset    = 1'b1;
  logic        start    = 1'b0;
  logic [2:0]  Multiop  = 3'b000;
  logic [31:0] A        = '0;
  logic [31:0] B        = '0;
  logic        d_md_use = 1'b0;
  logic        busy;
  logic        md_stall;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] md_out;

  int n_checks = 0;
  int n_fail   = 0;
  bit smp_busy;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .Multiop  (Multiop),
    .A        (A),
    .B        (B),
    .d_md_use (d_md_use),
    .busy     (busy),
    .md_stall (md_stall),
    .HI       (HI),
    .LO       (LO),
    .md_out   (md_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic in plain 64-bit integer math.
  function automatic logic [63:0] ref_calc(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd0: return sa * sb;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 32'd0) return 64'd0;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 32'd0) return 64'd0;
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Model: a pending result with an absolute commit edge number.
  logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit          m_pend = 1'b0, p_skip = 1'b0;
  longint      edge_no = 0, deadline = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi   <= '0;
      m_lo   <= '0;
      m_pend <= 1'b0;
    end else begin
      if (m_pend) begin
        if (edge_no == deadline) begin
          m_pend <= 1'b0;
          if (!p_skip) begin
            m_hi <= p_hi;
            m_lo <= p_lo;
          end
        end
      end else if (start && Multiop < 3'd4) begin
        {p_hi, p_lo} <= ref_calc(Multiop, A, B);
        p_skip       <= (Multiop >= 3'd2) && (B == 32'd0);
        deadline     <= edge_no + ((Multiop >= 3'd2) ? DC : MC);
        m_pend       <= 1'b1;
      end else if (Multiop == 3'd4) begin
        m_hi <= A;
      end else if (Multiop == 3'd5) begin
        m_lo <= A;
      end
      edge_no <= edge_no + 1;
    end
  end

  function automatic logic [31:0] exp_out();
    if (Multiop == 3'd7) return m_hi;
    if (Multiop == 3'd6) return m_lo;
    return 32'd0;
  endfunction

  always @(negedge clk) begin
    check("busy", {31'd0, busy}, {31'd0, m_pend});
    check("HI", HI, m_hi);
    check("LO", LO, m_lo);
    check("md_out", md_out, exp_out());
    check("md_stall", {31'd0, md_stall}, {31'd0, d_md_use & (start | m_pend)});
  end

  task automatic drive(input bit st, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit d);
    @(negedge clk);
    smp_busy = busy;
    #1;
    start    = st;
    Multiop  = op;
    A        = a;
    B        = b;
    d_md_use = d;
  endtask

  task automatic idle(input int n, input bit d, output int bc);
    bc = 0;
    repeat (n) begin
      drive(1'b0, 3'd0, 32'd0, 32'd0, d);
      if (smp_busy) bc++;
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit d, input int n_exp);
    int bc;
    drive(1'b1, op, a, b, d);
    #1 check({name, "_stall_start"}, {31'd0, md_stall}, {31'd0, d});
    idle(13, d, bc);
    check({name, "_busy_cycles"}, bc, n_exp);
    #1 check({name, "_stall_after"}, {31'd0, md_stall}, 32'd0);
  endtask

  initial begin
    int bc;
    drive(1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
    drive(1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
    #1 check("rst_mfhi", md_out, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset = 1'b0;

    do_op("mult", 3'd0, 32'hFFFFFFFD, 32'd5, 1'b1, 5);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFF1);
    drive(1'b0, 3'd6, 32'd0, 32'd0, 1'b0);
    #1 check("mflo", md_out, 32'hFFFFFFF1);

    do_op("multu", 3'd1, 32'hFFFFFFFF, 32'd2, 1'b0, 5);
    check("multu_hi", HI, 32'h00000001);
    check("multu_lo", LO, 32'hFFFFFFFE);

    do_op("div", 3'd2, 32'hFFFFFFF9, 32'd2, 1'b1, 10);
    check("div_lo", LO, 32'hFFFFFFFD);
    check("div_hi", HI, 32'hFFFFFFFF);

    drive(1'b0, 3'd4, 32'h1234, 32'd0, 1'b0);
    drive(1'b0, 3'd5, 32'h5678, 32'd0, 1'b0);
    do_op("div0", 3'd2, 32'd100, 32'd0, 1'b0, 10);
    check("div0_hi", HI, 32'h1234);
    check("div0_lo", LO, 32'h5678);
    do_op("divu0", 3'd3, 32'd100, 32'd0, 1'b0, 10);
    check("divu0_hi", HI, 32'h1234);
    check("divu0_lo", LO, 32'h5678);

    do_op("ovf", 3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 10);
    check("ovf_lo", LO, 32'h80000000);
    check("ovf_hi", HI, 32'h0);

    do_op("divu", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 10);
    check("divu_lo", LO, 32'h7FFFFFFC);
    check("divu_hi", HI, 32'h1);

    // mthi while busy is dropped; the same op in idle lands
    drive(1'b1, 3'd0, 32'd3, 32'd4, 1'b0);
    drive(1'b0, 3'd4, 32'hDEADBEEF, 32'd0, 1'b0);
    idle(8, 1'b0, bc);
    check("mt_busy_hi", HI, 32'h0);
    check("mt_busy_lo", LO, 32'd12);
    drive(1'b0, 3'd4, 32'hDEADBEEF, 32'd0, 1'b0);
    drive(1'b0, 3'd7, 32'd0, 32'd0, 1'b0);
    #1 check("mfhi", md_out, 32'hDEADBEEF);

    // second start during busy is ignored
    drive(1'b1, 3'd1, 32'd10, 32'd10, 1'b0);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    drive(1'b1, 3'd2, 32'd100, 32'd7, 1'b0);
    idle(12, 1'b0, bc);
    check("ign_busy_cycles", bc, 3);
    check("ign_hi", HI, 32'd0);
    check("ign_lo", LO, 32'd100);

    // asynchronous reset in the third busy cycle of a divide
    drive(1'b0, 3'd4, 32'hAAAA5555, 32'd0, 1'b0);
    drive(1'b1, 3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    idle(3, 1'b0, bc);
    #1 check("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_hi", HI, 32'd0);
    check("arst_lo", LO, 32'd0);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 1'b0);
    reset = 1'b0;
    do_op("mult67", 3'd0, 32'd6, 32'd7, 1'b0, 5);
    check("mult67_lo", LO, 32'd42);
    check("mult67_hi", HI, 32'd0);

    for (int i = 0; i < 600; i++) begin
      logic [31:0] ra, rb;
      int          sel;
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      rb  = (sel == 0) ? 32'd0 : (sel < 3) ? 32'($urandom_range(1, 9)) : $urandom;
      if ($urandom_range(0, 5) == 0) ra = -32'($urandom_range(1, 50));
      drive(($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), ra, rb,
            ($urandom_range(0, 1) == 1));
    end
    idle(15, 1'b0, bc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
